// File: rtl/ik_frame_sequencer_if.sv
// Control and status bundle between the ik_swift_32 frame sequencer and its consumers.
// master drives the run controls; slave (the sequencer) drives position and pulses.
interface ik_frame_sequencer_if #(
  parameter int CNT_W    = 8,
  parameter int N_STROBE = 2,
  parameter int FRM_W    = 16
);
  logic                en;
  logic                clr;
  logic                start;
  logic                continuous;
  logic                busy;
  logic [CNT_W-1:0]    count;
  logic [N_STROBE-1:0] strobe;
  logic                mode;
  logic                frame_done;
  logic [FRM_W-1:0]    frames_run;

  modport master (
    output en, clr, start, continuous,
    input  busy, count, strobe, mode, frame_done, frames_run
  );

  modport slave (
    input  en, clr, start, continuous,
    output busy, count, strobe, mode, frame_done, frames_run
  );
endinterface

// File: rtl/ik_frame_sequencer.sv
// Programmable frame sequencer: frame counter with start/busy/done handshake,
// one-shot or continuous runs, N strobe points and one active-low mode window.
module ik_frame_sequencer #(
  parameter int                          CNT_W     = 8,
  parameter int                          FRAME_LEN = 113,
  parameter int                          N_STROBE  = 2,
  parameter logic [N_STROBE*CNT_W-1:0]   STROBE_AT = {8'd98, 8'd28},
  parameter int                          WIN_LO    = 90,
  parameter int                          WIN_HI    = 99,
  parameter int                          FRM_W     = 16
) (
  input logic               clk,
  input logic               rst_n,
  ik_frame_sequencer_if.slave seq
);

  if (FRAME_LEN > (1 << CNT_W)) begin : g_bad_frame_len
    $error("ik_frame_sequencer: FRAME_LEN %0d does not fit in CNT_W %0d", FRAME_LEN, CNT_W);
  end
  if (!(WIN_LO < WIN_HI && WIN_HI <= FRAME_LEN)) begin : g_bad_window
    $error("ik_frame_sequencer: need WIN_LO < WIN_HI <= FRAME_LEN (%0d, %0d, %0d)",
           WIN_LO, WIN_HI, FRAME_LEN);
  end
  if (N_STROBE < 1) begin : g_bad_n_strobe
    $error("ik_frame_sequencer: N_STROBE must be at least 1");
  end
  for (genvar gi = 0; gi < N_STROBE; gi++) begin : g_chk_strobe
    if (int'(STROBE_AT[gi*CNT_W +: CNT_W]) >= FRAME_LEN) begin : g_bad_strobe
      $error("ik_frame_sequencer: STROBE_AT slice %0d is outside the frame", gi);
    end
  end

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
  // Window bounds may equal 2**CNT_W, so compare with one extra bit.
  localparam logic [CNT_W:0]   WIN_LO_C = (CNT_W+1)'(WIN_LO);
  localparam logic [CNT_W:0]   WIN_HI_C = (CNT_W+1)'(WIN_HI);

  function automatic logic [FRM_W-1:0] sat_inc(input logic [FRM_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [N_STROBE-1:0] strobe;
  logic                frame_done;
  logic [FRM_W-1:0]    frames_run;
  logic [N_STROBE-1:0] strobe_hit;
  logic                in_window;

  always_comb begin
    strobe_hit = '0;
    for (int i = 0; i < N_STROBE; i++) begin
      strobe_hit[i] = (count == STROBE_AT[i*CNT_W +: CNT_W]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      strobe     <= '0;
      frame_done <= 1'b0;
      frames_run <= '0;
    end else if (seq.clr) begin
      state      <= IDLE;
      count      <= '0;
      strobe     <= '0;
      frame_done <= 1'b0;
      frames_run <= '0;
    end else begin
      // Pulses default low so a stall can never stretch them.
      strobe     <= '0;
      frame_done <= 1'b0;
      if (seq.en) begin
        case (state)
          IDLE: begin
            count <= '0;
            if (seq.start) state <= RUN;
          end
          RUN: begin
            strobe <= strobe_hit;
            if (count == CNT_LAST) begin
              count      <= '0;
              frame_done <= 1'b1;
              frames_run <= sat_inc(frames_run);
              if (!seq.continuous) state <= IDLE;
            end else begin
              count <= count + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign in_window = ({1'b0, count} >= WIN_LO_C) && ({1'b0, count} < WIN_HI_C);

  assign seq.busy       = (state == RUN);
  assign seq.count      = count;
  assign seq.strobe     = strobe;
  assign seq.mode       = ~((state == RUN) && in_window);
  assign seq.frame_done = frame_done;
  assign seq.frames_run = frames_run;

endmodule

// File: tb/tb_ik_frame_sequencer.sv
// Bench for ik_frame_sequencer: legacy-default instance checked cycle by cycle against a
// behavioural model through a scoreboard queue, plus a 4-count instance driven from a vector table.
module tb_ik_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ik_frame_sequencer_if #(.CNT_W(8), .N_STROBE(2), .FRM_W(16)) bif();
  ik_frame_sequencer_if #(.CNT_W(2), .N_STROBE(2), .FRM_W(2))  sif();

  ik_frame_sequencer dut_big (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (bif.slave)
  );

  ik_frame_sequencer #(
    .CNT_W(2), .FRAME_LEN(4), .N_STROBE(2), .STROBE_AT({2'd0, 2'd3}),
    .WIN_LO(1), .WIN_HI(3), .FRM_W(2)
  ) dut_small (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (sif.slave)
  );

  typedef struct packed {
    logic        busy;
    logic [7:0]  count;
    logic [1:0]  strobe;
    logic        mode;
    logic        done;
    logic [15:0] frames;
  } bout_t;

  typedef struct packed {
    logic       busy;
    logic [1:0] count;
    logic [1:0] strobe;
    logic       mode;
    logic       done;
    logic [1:0] frames;
  } sout_t;

  typedef struct {
    bit    en, clr, start, cont;
    sout_t exp;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  // reference model of the default-parameter sequencer
  bit       m_run;
  int       m_cnt;
  bit [1:0] m_str;
  bit       m_done;
  int       m_frm;

  bout_t sb_big[$];
  sout_t sb_small[$];
  vec_t  vecs[$];

  int cyc_n, busy_cnt, s0_cnt, s1_cnt, mode0_cnt;
  int done_cyc[$];

  function automatic bout_t big_now();
    return '{busy: bif.busy, count: bif.count, strobe: bif.strobe, mode: bif.mode,
             done: bif.frame_done, frames: bif.frames_run};
  endfunction

  function automatic bout_t model_out();
    bout_t o;
    o.busy   = m_run;
    o.count  = 8'(m_cnt);
    o.strobe = m_str;
    o.mode   = !(m_run && m_cnt >= 90 && m_cnt < 99);
    o.done   = m_done;
    o.frames = 16'(m_frm);
    return o;
  endfunction

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_str = 0; m_done = 0; m_frm = 0;
  endtask

  task automatic model_step(input bit en, input bit clr, input bit start, input bit cont);
    if (clr) begin
      model_reset();
      return;
    end
    m_str  = 0;
    m_done = 0;
    if (!en) return;
    if (!m_run) begin
      m_cnt = 0;
      m_run = start;
    end else begin
      m_str[0] = (m_cnt == 28);
      m_str[1] = (m_cnt == 98);
      if (m_cnt == 112) begin
        m_cnt  = 0;
        m_done = 1;
        if (m_frm < 65535) m_frm++;
        m_run = cont;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_big(input string name, input bout_t a, input bout_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got busy=%0b count=%0d strobe=%b mode=%0b done=%0b frames=%0d, want busy=%0b count=%0d strobe=%b mode=%0b done=%0b frames=%0d",
               name, a.busy, a.count, a.strobe, a.mode, a.done, a.frames,
               e.busy, e.count, e.strobe, e.mode, e.done, e.frames);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_chk++;
    if (a != e) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; s0_cnt = 0; s1_cnt = 0; mode0_cnt = 0;
    done_cyc.delete();
  endtask

  // One clock on the default instance: drive, predict, then compare after the edge.
  task automatic cyc(input bit en, input bit clr, input bit start, input bit cont);
    bout_t a;
    bout_t e;
    bif.en = en; bif.clr = clr; bif.start = start; bif.continuous = cont;
    model_step(en, clr, start, cont);
    sb_big.push_back(model_out());
    @(posedge clk);
    #1;
    cyc_n++;
    a = big_now();
    if (a.done) done_cyc.push_back(cyc_n);
    if (a.busy) busy_cnt++;
    if (a.strobe[0]) s0_cnt++;
    if (a.strobe[1]) s1_cnt++;
    if (!a.mode) mode0_cnt++;
    e = sb_big.pop_front();
    check_big($sformatf("seq@%0d", cyc_n), a, e);
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 200 && m_cnt != target; k++) cyc(1, 0, 0, 0);
  endtask

  function automatic vec_t mk(input bit en, input bit clr, input bit start, input bit cont,
                              input bit busy, input int count, input bit [1:0] strobe,
                              input bit mode, input bit done, input int frames);
    vec_t v;
    v.en = en; v.clr = clr; v.start = start; v.cont = cont;
    v.exp = '{busy: busy, count: 2'(count), strobe: strobe, mode: mode, done: done,
              frames: 2'(frames)};
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bout_t rst_exp;
    sout_t sa;
    sout_t se;
    rst_exp = '{busy: 1'b0, count: 8'd0, strobe: 2'b00, mode: 1'b1, done: 1'b0, frames: 16'd0};
    cyc_n = 0;
    clear_stats();
    model_reset();
    rst_n = 1'b0;
    bif.en = 0; bif.clr = 0; bif.start = 0; bif.continuous = 0;
    sif.en = 0; sif.clr = 0; sif.start = 0; sif.continuous = 0;

    #7;
    check_big("reset_state", big_now(), rst_exp);
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single frame with defaults
    clear_stats();
    cyc(1, 0, 1, 0);
    for (int k = 0; k < 200 && m_run; k++) cyc(1, 0, 0, 0);
    check_int("t1_busy_cycles", busy_cnt, 113);
    check_int("t1_strobe0", s0_cnt, 1);
    check_int("t1_strobe1", s1_cnt, 1);
    check_int("t1_mode0_cycles", mode0_cnt, 9);
    check_int("t1_frame_done", done_cyc.size(), 1);
    check_int("t1_frames_run", int'(bif.frames_run), 1);
    check_int("t1_idle", int'(bif.busy), 0);

    // start with en low must not be latched
    cyc(0, 0, 1, 0);
    cyc(1, 0, 0, 0);
    check_int("start_no_latch", int'(bif.busy), 0);

    // 2: continuous run for three frames
    cyc(1, 1, 0, 0);
    clear_stats();
    cyc(1, 0, 1, 1);
    for (int k = 0; k < 113 * 2 + 50; k++) cyc(1, 0, 0, 1);
    for (int k = 0; k < 300 && m_run; k++) cyc(1, 0, 0, 0);
    check_int("t2_frame_done", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check_int("t2_spacing_a", done_cyc[1] - done_cyc[0], 113);
      check_int("t2_spacing_b", done_cyc[2] - done_cyc[1], 113);
    end
    check_int("t2_frames_run", int'(bif.frames_run), 3);
    check_int("t2_idle", int'(bif.busy), 0);

    // 3: stall at count 27
    clear_stats();
    cyc(1, 0, 1, 0);
    run_to(27);
    repeat (5) cyc(0, 0, 0, 0);
    check_int("t3_stall_hold", int'(bif.count), 27);
    check_int("t3_no_strobe_in_stall", s0_cnt, 0);
    for (int k = 0; k < 200 && m_run; k++) cyc(1, 0, 0, 0);
    check_int("t3_strobe0_once", s0_cnt, 1);
    check_int("t3_frames_run", int'(bif.frames_run), 4);

    // 4: clr mid-frame with start, then clr on the wrap edge
    clear_stats();
    cyc(1, 0, 1, 0);
    run_to(60);
    cyc(1, 1, 1, 0);
    check_int("t4_clr_busy", int'(bif.busy), 0);
    check_int("t4_clr_frames", int'(bif.frames_run), 0);
    cyc(1, 0, 1, 0);
    check_int("t4_restart_count", int'(bif.count), 0);
    run_to(112);
    cyc(1, 1, 0, 1);
    check_int("t4_clr_wrap_no_done", done_cyc.size(), 0);
    check_int("t4_clr_wrap_idle", int'(bif.busy), 0);

    // 5: asynchronous reset mid-clock
    cyc(1, 0, 1, 0);
    run_to(50);
    #3 rst_n = 1'b0;
    #1;
    check_big("t5_async_reset", big_now(), rst_exp);
    bif.en = 1; bif.start = 1;
    repeat (3) @(posedge clk);
    #1;
    check_big("t5_reset_hold", big_now(), rst_exp);
    bif.start = 0;
    #3 rst_n = 1'b1;
    model_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    check_int("t5_restart_count", int'(bif.count), 1);
    cyc(1, 1, 0, 0);

    // 6: four-count frame from a vector table
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 2'b00, 1, 0, 0));
    for (int f = 0; f < 4; f++) begin
      vecs.push_back(mk(1, 0, 0, 1, 1, 1, 2'b10, 0, 0, f));
      vecs.push_back(mk(1, 0, 0, 1, 1, 2, 2'b00, 0, 0, f));
      vecs.push_back(mk(1, 0, 0, 1, 1, 3, 2'b00, 1, 0, f));
      vecs.push_back(mk(1, 0, 0, 1, 1, 0, 2'b01, 1, 1, (f + 1 > 3) ? 3 : f + 1));
    end
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 2'b00, 1, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 2'b10, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 1, 2, 2'b00, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 1, 3, 2'b00, 1, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b01, 1, 1, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 1, 0, 3));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 2'b00, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      sif.en = vecs[i].en; sif.clr = vecs[i].clr;
      sif.start = vecs[i].start; sif.continuous = vecs[i].cont;
      sb_small.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      sa = '{busy: sif.busy, count: sif.count, strobe: sif.strobe, mode: sif.mode,
             done: sif.frame_done, frames: sif.frames_run};
      se = sb_small.pop_front();
      n_chk++;
      if (sa !== se) begin
        n_fail++;
        $display("FAIL vec[%0d]: got busy=%0b count=%0d strobe=%b mode=%0b done=%0b frames=%0d, want busy=%0b count=%0d strobe=%b mode=%0b done=%0b frames=%0d",
                 i, sa.busy, sa.count, sa.strobe, sa.mode, sa.done, sa.frames,
                 se.busy, se.count, se.strobe, se.mode, se.done, se.frames);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
